acc_seq_ctrl: RTL and testbench
===============================

Name: acc_seq_ctrl

Overview:
Multi-cycle control sequencer for the 16-bit accumulator CPU datapath (IR/MD/AC 16-bit, PC/MA 12-bit, 3-bit opcode plus AM indirect bit).
- Walks each instruction through fetch, decode, optional indirect, operand and execute phases.
- Drives one-cycle load/increment strobes into the datapath registers.
- Talks to a variable-latency word memory through a req/ack handshake.
- Replaces ad-hoc single-cycle sequencing, so memory reads complete before their data is consumed.

Parameters:
- OPC_W, 3, opcode width.
- ST_W, 4, width of the state debug output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  level; allows fetching of new instructions
- ir_opcode  in  3  IR[15:13]
- ir_am  in  1  IR[12]; 1 = indirect
- ac_nonzero  in  1  AC != 0
- mem_ack  in  1  memory completed the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write AC to M[MA], 0 = read
- addr_sel  out  1  0 = PC, 1 = MA drives the memory address
- ir_ld  out  1  IR <= memory data
- pc_inc  out  1  PC <= PC+1
- pc_ld_ir  out  1  PC <= IR[11:0]
- pc_ld_md  out  1  PC <= MD[11:0]
- ma_ld_ir  out  1  MA <= IR[11:0]
- ma_ld_md  out  1  MA <= MD[11:0]
- md_ld  out  1  MD <= memory data
- ac_ld  out  1  AC <= result selected by ac_op
- ac_op  out  2  0 = ~AC, 1 = AC+MD, 2 = AC+1, 3 = MD
- ac_clr  out  1  AC <= 0
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- halted  out  1  high in HALT
- state  out  4  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, IND_RD=3, IND_MA=4, OP_RD=5, EXEC=6, STORE=7, HALT=8.
- Reset (synchronous): state=IDLE.
  - All strobes, mem_req, mem_we, instr_done and halted are 0.
  - A reset during an outstanding request drops mem_req on the next edge with no write strobe.
  - A late mem_ack after reset is ignored.
- Strobes are combinational decodes of state, mem_ack, opcode, am and ac_nonzero. Each strobe is asserted for exactly one cycle.
- Memory handshake:
  - In FETCH, IND_RD, OP_RD and STORE, mem_req=1 and addr_sel/mem_we are held stable until mem_ack=1.
  - mem_ack may arrive in the first cycle of the request (zero wait).
  - mem_ack is ignored whenever mem_req=0.
- IDLE: run=1 -> FETCH.
- FETCH: addr_sel=0, read. On mem_ack: ir_ld=1, pc_inc=1 -> DECODE.
- DECODE (one cycle) does ma_ld_ir=1, except for branches. Next state by opcode:
  - 000 NOT -> EXEC.
  - 011 INC -> EXEC.
  - 001 ADD, 101 LOAD, 100 STORE: am=1 -> IND_RD; am=0 -> OP_RD (STORE: -> STORE).
  - 010 BR, ac_nonzero=0: instr_done.
  - 010 BR, ac_nonzero=1, am=0: pc_ld_ir=1, instr_done.
  - 010 BR, ac_nonzero=1, am=1: ma_ld_ir=1 -> IND_RD.
  - 110/111: -> HALT.
- IND_RD: read M[MA]. On ack: md_ld=1.
  - Branch: -> IND_MA, with pc_ld_md=1 and instr_done issued in IND_MA instead of ma_ld_md.
  - Otherwise -> IND_MA.
- IND_MA (one cycle): ma_ld_md=1. Next: ADD/LOAD -> OP_RD; STORE -> STORE.
- OP_RD: read M[MA]. On ack: md_ld=1 -> EXEC.
- EXEC (one cycle): ac_ld=1, instr_done=1.
  - ac_op: NOT=0, ADD=1, INC=2, LOAD=3.
  - ADD and INC wrap modulo 2^16; there is no carry out.
- STORE: mem_we=1, addr_sel=1. On ack: ac_clr=1, instr_done=1.
- Instruction end: after instr_done, next state = FETCH if run=1, else IDLE.
  - Dropping run mid-instruction never aborts the instruction.
- HALT: halted=1. Exited only by reset; run is ignored.
- Zero-wait latencies:
  - NOT/INC: 3 cycles.
  - LOAD/ADD: 4 cycles direct, 6 indirect.
  - STORE: 3 direct, 5 indirect.
  - BR taken: 2 direct, 4 indirect.
  - BR not taken: 2.
- Each wait cycle adds exactly one cycle.
- PC wrap (0xFFF+1 -> 0x000) is a datapath property; the controller imposes no limit.

Optional Feature:
ACC_SEQ_SINGLE_STEP_EN
- Adds input `step` (1 bit).
- When defined, the instruction-end transition to FETCH also requires a rising edge of `step`, detected by an internal registered copy. Otherwise the controller waits in IDLE.
- A step pulse during an instruction is remembered (one deep) and consumed at the next boundary.
- When undefined, the port is absent and the behaviour is exactly as above.

Test Plan:
1. reset=1 for 2 cycles, then run=1, zero-wait memory, NOT direct -> state 1,2,6. ac_ld with ac_op=0 and instr_done in cycle 3; then FETCH.
2. LOAD indirect (opcode 101, am=1), ack delayed 2 cycles on every request -> strobe order ir_ld, ma_ld_ir, md_ld, ma_ld_md, md_ld, ac_ld (ac_op=3); 12 cycles total.
3. BR with ac_nonzero=0 -> no pc_ld_*, instr_done in DECODE. BR direct with ac_nonzero=1 -> pc_ld_ir in DECODE.
4. STORE direct, ack on 3rd cycle of request -> mem_we=1 and addr_sel=1 held stable for 3 cycles; ac_clr and instr_done together with ack.
5. Reset asserted mid-OP_RD, then a late ack -> mem_req=0 next cycle, state=IDLE, no md_ld. Opcode 111 -> halted=1 and stays with run=1 until reset.
6. run dropped during EXEC of INC -> instruction completes (ac_op=2), then IDLE with no further mem_req.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// Multi-cycle control sequencer for the 16-bit accumulator CPU datapath.
// Optional single-step gating is enabled with `define ACC_SEQ_SINGLE_STEP_EN.
module acc_seq_ctrl #(
    parameter int unsigned OPC_W = 3,
    parameter int unsigned ST_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             ir_am,
    input  logic             ac_nonzero,
    input  logic             mem_ack,
`ifdef ACC_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld_ir,
    output logic             pc_ld_md,
    output logic             ma_ld_ir,
    output logic             ma_ld_md,
    output logic             md_ld,
    output logic             ac_ld,
    output logic [1:0]       ac_op,
    output logic             ac_clr,
    output logic             instr_done,
    output logic             halted,
    output logic [ST_W-1:0]  state
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StIndRd  = 4'd3,
        StIndMa  = 4'd4,
        StOpRd   = 4'd5,
        StExec   = 4'd6,
        StStore  = 4'd7,
        StHalt   = 4'd8
    } state_e;

    localparam logic [OPC_W-1:0] OpNot   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OpAdd   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OpBr    = OPC_W'(2);
    localparam logic [OPC_W-1:0] OpInc   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OpStore = OPC_W'(4);
    localparam logic [OPC_W-1:0] OpLoad  = OPC_W'(5);

    state_e state_q, state_d, end_state;
    logic   go_fetch;
    logic   is_br;

    assign is_br = (ir_opcode == OpBr);

`ifdef ACC_SEQ_SINGLE_STEP_EN
    logic step_q, step_pend_q, step_rise, consumed;

    // A step edge seen mid-instruction is held until the next boundary.
    assign step_rise = step & ~step_q;
    assign go_fetch  = run & (step_rise | step_pend_q);
    assign consumed  = go_fetch & ((state_q == StIdle) | instr_done);

    always_ff @(posedge clk) begin
        step_q <= step;
        if (reset || consumed) begin
            step_pend_q <= 1'b0;
        end else if (step_rise) begin
            step_pend_q <= 1'b1;
        end
    end
`else
    assign go_fetch = run;
`endif

    assign end_state = go_fetch ? StFetch : StIdle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (go_fetch) state_d = StFetch;
            StFetch:  if (mem_ack) state_d = StDecode;
            StDecode: begin
                case (ir_opcode)
                    OpNot, OpInc:   state_d = StExec;
                    OpAdd, OpLoad:  state_d = ir_am ? StIndRd : StOpRd;
                    OpStore:        state_d = ir_am ? StIndRd : StStore;
                    OpBr:           state_d = (ac_nonzero && ir_am) ? StIndRd : end_state;
                    default:        state_d = StHalt;
                endcase
            end
            StIndRd:  if (mem_ack) state_d = StIndMa;
            StIndMa: begin
                if (is_br) begin
                    state_d = end_state;
                end else if (ir_opcode == OpStore) begin
                    state_d = StStore;
                end else begin
                    state_d = StOpRd;
                end
            end
            StOpRd:   if (mem_ack) state_d = StExec;
            StExec:   state_d = end_state;
            StStore:  if (mem_ack) state_d = end_state;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld_ir   = 1'b0;
        pc_ld_md   = 1'b0;
        ma_ld_ir   = 1'b0;
        ma_ld_md   = 1'b0;
        md_ld      = 1'b0;
        ac_ld      = 1'b0;
        ac_op      = 2'd0;
        ac_clr     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                ir_ld   = mem_ack;
                pc_inc  = mem_ack;
            end
            StDecode: begin
                if (!is_br) begin
                    ma_ld_ir = 1'b1;
                end else if (!ac_nonzero) begin
                    instr_done = 1'b1;
                end else if (!ir_am) begin
                    pc_ld_ir   = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    ma_ld_ir = 1'b1;
                end
            end
            StIndRd, StOpRd: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                md_ld    = mem_ack;
            end
            StIndMa: begin
                // Indirect branch target goes straight to PC instead of MA.
                pc_ld_md   = is_br;
                instr_done = is_br;
                ma_ld_md   = ~is_br;
            end
            StExec: begin
                ac_ld      = 1'b1;
                instr_done = 1'b1;
                case (ir_opcode)
                    OpAdd:   ac_op = 2'd1;
                    OpInc:   ac_op = 2'd2;
                    OpLoad:  ac_op = 2'd3;
                    default: ac_op = 2'd0;
                endcase
            end
            StStore: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                addr_sel   = 1'b1;
                ac_clr     = mem_ack;
                instr_done = mem_ack;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = ST_W'(state_q);

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Randomized bench for acc_seq_ctrl: a phase-level instruction model expands each
// instruction into expected per-cycle outputs, compared against the DUT every cycle.
module tb_acc_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, ir_am, ac_nonzero, mem_ack;
    logic [2:0] ir_opcode;
    logic       mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld_ir, pc_ld_md;
    logic       ma_ld_ir, ma_ld_md, md_ld, ac_ld, ac_clr, instr_done, halted;
    logic [1:0] ac_op;
    logic [3:0] state;

    always #5 clk = ~clk;

`ifdef ACC_SEQ_SINGLE_STEP_EN
    logic step = 1'b0;
    always @(posedge clk) step <= ~step;
`endif

    acc_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .ir_am      (ir_am),
        .ac_nonzero (ac_nonzero),
        .mem_ack    (mem_ack),
`ifdef ACC_SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .pc_ld_ir   (pc_ld_ir),
        .pc_ld_md   (pc_ld_md),
        .ma_ld_ir   (ma_ld_ir),
        .ma_ld_md   (ma_ld_md),
        .md_ld      (md_ld),
        .ac_ld      (ac_ld),
        .ac_op      (ac_op),
        .ac_clr     (ac_clr),
        .instr_done (instr_done),
        .halted     (halted),
        .state      (state)
    );

    localparam int unsigned S_REQ = 1, S_WE = 2, S_ASEL = 4, S_IRLD = 8, S_PCINC = 16;
    localparam int unsigned S_PCIR = 32, S_PCMD = 64, S_MAIR = 128, S_MAMD = 256;
    localparam int unsigned S_MDLD = 512, S_ACLD = 1024, S_ACCLR = 2048, S_DONE = 4096;
    localparam int unsigned S_HALT = 8192;

    typedef struct {
        logic        ack;
        logic        run;
        logic [2:0]  op;
        logic        am;
        logic        nz;
        int unsigned exp;
    } rec_t;

    rec_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          ncyc = 0;
    logic [2:0]  cur_op;
    logic        cur_am, cur_nz;
    int          cur_w;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ac_op is only meaningful with ac_ld; addr_sel/mem_we only with mem_req.
    function automatic logic [31:0] observed();
        return {12'b0, state, (ac_ld ? ac_op : 2'b00), halted, instr_done, ac_clr, ac_ld,
                md_ld, ma_ld_md, ma_ld_ir, pc_ld_md, pc_ld_ir, pc_inc, ir_ld,
                mem_req & addr_sel, mem_req & mem_we, mem_req};
    endfunction

    function automatic int wt();
        return (cur_w >= 0) ? cur_w : int'($urandom_range(0, 3));
    endfunction

    task automatic push(input int unsigned st, input int unsigned flags, input int unsigned acop,
                        input logic ack, input logic rn);
        rec_t r;
        r.ack = ack;
        r.run = rn;
        r.op  = cur_op;
        r.am  = cur_am;
        r.nz  = cur_nz;
        r.exp = (st << 16) | (acop << 14) | flags;
        q.push_back(r);
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic mem_phase(input int unsigned st, input int unsigned base,
                             input int unsigned ackf, input int unsigned acop, input logic rn);
        int w = wt();
        for (int i = 0; i < w; i++) push(st, base, 0, 1'b0, 1'b1);
        push(st, base | ackf, acop, 1'b1, rn);
    endtask

    // Expected cycles for one instruction; rn_end is run during its last cycle.
    task automatic add_instr(input logic [2:0] op, input logic am, input logic nz,
                             input logic rn_end, input int w);
        cur_op = op;
        cur_am = am;
        cur_nz = nz;
        cur_w  = w;
        mem_phase(1, S_REQ, S_IRLD | S_PCINC, 0, 1'b1);
        if (op == 3'd2) begin
            if (!nz) begin
                push(2, S_DONE, 0, noise(), rn_end);
            end else if (!am) begin
                push(2, S_PCIR | S_DONE, 0, noise(), rn_end);
            end else begin
                push(2, S_MAIR, 0, noise(), 1'b1);
                mem_phase(3, S_REQ | S_ASEL, S_MDLD, 0, 1'b1);
                push(4, S_PCMD | S_DONE, 0, noise(), rn_end);
            end
        end else if (op >= 3'd6) begin
            push(2, S_MAIR, 0, noise(), 1'b1);
            for (int i = 0; i < 5; i++) push(8, S_HALT, 0, noise(), 1'b1);
            return;
        end else begin
            push(2, S_MAIR, 0, noise(), 1'b1);
            if (op == 3'd0 || op == 3'd3) begin
                push(6, S_ACLD | S_DONE, (op == 3'd0) ? 0 : 2, noise(), rn_end);
            end else begin
                if (am) begin
                    mem_phase(3, S_REQ | S_ASEL, S_MDLD, 0, 1'b1);
                    push(4, S_MAMD, 0, noise(), 1'b1);
                end
                if (op == 3'd4) begin
                    mem_phase(7, S_REQ | S_WE | S_ASEL, S_ACCLR | S_DONE, 0, rn_end);
                end else begin
                    mem_phase(5, S_REQ | S_ASEL, S_MDLD, 0, 1'b1);
                    push(6, S_ACLD | S_DONE, (op == 3'd1) ? 1 : 3, noise(), rn_end);
                end
            end
        end
        if (!rn_end) begin
            int k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) push(0, 0, 0, noise(), 1'b0);
            push(0, 0, 0, noise(), 1'b1);
        end
    endtask

    task automatic run_q();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            mem_ack    = r.ack;
            run        = r.run;
            ir_opcode  = r.op;
            ir_am      = r.am;
            ac_nonzero = r.nz;
            @(negedge clk);
            check_eq($sformatf("cyc%0d", ncyc), observed(), 32'(r.exp));
            @(posedge clk);
            #1;
            ncyc++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        mem_ack    = 1'b0;
        ir_opcode  = 3'd0;
        ir_am      = 1'b0;
        ac_nonzero = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_outputs", observed(), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cur_op = 3'd0; cur_am = 1'b0; cur_nz = 1'b0;
        push(0, 0, 0, 1'b0, 1'b1);
        add_instr(3'd0, 1'b0, 1'b0, 1'b1, 0);  // NOT direct, zero wait
        add_instr(3'd5, 1'b1, 1'b0, 1'b1, 2);  // LOAD indirect, two waits per request
        add_instr(3'd2, 1'b0, 1'b0, 1'b1, 0);  // BR not taken
        add_instr(3'd2, 1'b0, 1'b1, 1'b1, 0);  // BR taken direct
        add_instr(3'd2, 1'b1, 1'b1, 1'b1, 1);  // BR taken indirect
        add_instr(3'd4, 1'b0, 1'b0, 1'b1, 2);  // STORE direct, ack on 3rd cycle
        add_instr(3'd3, 1'b0, 1'b0, 1'b0, 0);  // INC with run dropped in EXEC
        run_q();

        for (int n = 0; n < 200; n++) begin
            add_instr(3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), -1);
            run_q();
        end

        add_instr(3'($urandom_range(6, 7)), 1'b0, 1'b0, 1'b1, -1);
        run_q();

        reset   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset during an outstanding OP_RD read, followed by a late ack.
        cur_op = 3'd5; cur_am = 1'b0; cur_nz = 1'b0; cur_w = 0;
        push(0, 0, 0, 1'b0, 1'b1);
        mem_phase(1, S_REQ, S_IRLD | S_PCINC, 0, 1'b1);
        push(2, S_MAIR, 0, 1'b0, 1'b1);
        push(5, S_REQ | S_ASEL, 0, 1'b0, 1'b1);
        run_q();
        reset   = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b1;
        run     = 1'b0;
        @(negedge clk);
        check_eq("late_ack_after_reset", observed(), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_eq("idle_after_reset", observed(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
